des_round_sequencer: RTL and testbench
======================================

// Module: des_round_sequencer
// PURPOSE
//  Sequences the 3DES round datapath: accepts one 64-bit block request, loads the round register,
//  steps it through PASSES x ROUNDS Feistel rounds, and presents completion via valid/ready.
//  Drives round/pass indices, key-schedule select, per-pass direction and final-round swap inhibit.
//  Sits between the block-level input/output handshake logic and the round register + f-function.
// PARAMETERS
//  ROUNDS   16  Feistel rounds per DES pass
//  PASSES   3   DES passes per block (EDE)
//  ROUND_W  4   width of round_idx; must hold ROUNDS-1
// PORTS
//  clk           in   1        system clock, all logic on rising edge
//  rst           in   1        synchronous, active-high reset
//  start_valid   in   1        block request present
//  start_ready   out  1        sequencer can accept a request
//  mode          in   1        0 = encrypt (E-D-E), 1 = decrypt (D-E-D); sampled on accept
//  load          out  1        round register loads IP(data_in) this cycle
//  clear         out  1        round register clears this cycle
//  round_en      out  1        round register advances one round this cycle
//  round_idx     out  ROUND_W  current round 0..ROUNDS-1 (subkey index)
//  pass_idx      out  2        current pass 0..PASSES-1
//  pass_decrypt  out  1        current pass runs subkeys in reverse order
//  key_sel       out  2        key for current pass: 0=K1, 1=K2, 2=K3
//  last_round    out  1        final round of a pass: datapath inhibits L/R swap
//  done_valid    out  1        result in round register is final
//  done_ready    in   1        consumer takes the result
//  busy          out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; round_idx, pass_idx, mode latch = 0; while rst=1 every output is 0
//    (start_ready is gated by ~rst). start_ready=1 on the first cycle after rst drops.
//  - States: IDLE -> LOAD -> ROUND -> DONE -> IDLE.
//  - IDLE: start_ready=1. On start_valid&start_ready, latch mode and go to LOAD. Otherwise hold.
//  - LOAD: one cycle; load=1, round_idx=0, pass_idx=0; go to ROUND.
//  - ROUND: round_en=1 every cycle. round_idx increments; at ROUNDS-1 it wraps to 0 and pass_idx
//    increments. last_round=1 when round_idx==ROUNDS-1. When round_idx==ROUNDS-1 and
//    pass_idx==PASSES-1, go to DONE. Occupancy is exactly PASSES*ROUNDS cycles (48 by default).
//  - Latency: accept on edge A; LOAD in cycle A+1; ROUND in A+2..A+49; done_valid=1 from A+50.
//  - pass_decrypt = mode ^ pass_idx[0]. key_sel = mode ? (PASSES-1-pass_idx) : pass_idx.
//  - DONE: done_valid=1 and held until done_ready. On done_valid&done_ready: clear=1 in that same
//    cycle, then IDLE. done_valid must not drop without the handshake.
//  - start_valid outside IDLE is ignored, and no request is queued. Peak throughput is one block
//    per 51 cycles with done_ready tied high.
//  - Changes on mode after accept have no effect until the next accept.
//  - rst asserted in any state: IDLE and reset values on the next edge. No clear pulse is issued,
//    because the round register resets itself.
//  - load, round_en and clear are mutually exclusive in every cycle.
// CONFIGURATION
//  SEQ_ABORT_EN defined: adds input port abort (1 bit). abort=1 in LOAD, ROUND or DONE forces
//    clear=1 that cycle and returns to IDLE on the next edge, with no done_valid. abort in IDLE
//    is ignored. abort and done handshake in the same cycle: abort wins, though clear=1 either way.
//  SEQ_ABORT_EN undefined: the port is absent and a block always runs to DONE.
// TESTING
//  1 Reset: hold rst 3 cycles with start_valid=1 -> all outputs 0. First cycle after release:
//    start_ready=1 and busy=0.
//  2 Encrypt: mode=0, accept at cycle 0 -> load@1; round_en@2..49; key_sel 0,1,2 and
//    pass_decrypt 0,1,0 per 16-cycle pass; last_round@17,33,49; done_valid@50.
//  3 Decrypt: mode=1 -> key_sel 2,1,0 and pass_decrypt 1,0,1. Toggling mode mid-block changes
//    neither.
//  4 Backpressure: done_ready=0 for 10 cycles -> done_valid stays 1, start_valid ignored.
//    Then done_ready=1 -> clear pulse, start_ready=1 the next cycle.
//  5 Reset mid-block: rst at round 7 of pass 1 -> next cycle IDLE, indices 0, no done_valid.
//  6 SEQ_ABORT_EN: abort at cycle 20 -> clear=1@20, IDLE@21, no done_valid. A new request is
//    accepted @21.

Source files
------------

// File: rtl/des_round_sequencer_if.sv
// Handshake and round-control bundle between the 3DES round sequencer and its neighbours.
// master = sequencer side, slave = block I/O / datapath side.
interface des_round_sequencer_if #(
    parameter int unsigned ROUND_W = 4
);
    logic               start_valid;
    logic               start_ready;
    logic               mode;
    logic               load;
    logic               clear;
    logic               round_en;
    logic [ROUND_W-1:0] round_idx;
    logic [1:0]         pass_idx;
    logic               pass_decrypt;
    logic [1:0]         key_sel;
    logic               last_round;
    logic               done_valid;
    logic               done_ready;
    logic               busy;

    modport master (
        input  start_valid, mode, done_ready,
        output start_ready, load, clear, round_en, round_idx, pass_idx,
               pass_decrypt, key_sel, last_round, done_valid, busy
    );

    modport slave (
        output start_valid, mode, done_ready,
        input  start_ready, load, clear, round_en, round_idx, pass_idx,
               pass_decrypt, key_sel, last_round, done_valid, busy
    );
endinterface

// File: rtl/des_round_sequencer.sv
// 3DES round sequencer: accept, load, PASSES x ROUNDS Feistel rounds, then hold the result.
// Optional macro SEQ_ABORT_EN adds an abort input that clears the round register and returns to IDLE.
module des_round_sequencer #(
    parameter int unsigned ROUNDS  = 16,
    parameter int unsigned PASSES  = 3,
    parameter int unsigned ROUND_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SEQ_ABORT_EN
    input  logic                  abort,
`endif
    des_round_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [1:0]         pass_q, pass_d;
    logic               mode_q, mode_d;

    logic abort_w;
    logic last_w;
    logic start_ready_c, load_c, clear_c, round_en_c, last_round_c, done_valid_c;
    logic pass_decrypt_c;
    logic [1:0] key_sel_c;

`ifdef SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign last_w = (round_q == ROUND_W'(ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            pass_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            pass_q  <= pass_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        round_d        = round_q;
        pass_d         = pass_q;
        mode_d         = mode_q;
        start_ready_c  = 1'b0;
        load_c         = 1'b0;
        clear_c        = 1'b0;
        round_en_c     = 1'b0;
        last_round_c   = 1'b0;
        done_valid_c   = 1'b0;
        pass_decrypt_c = 1'b0;
        key_sel_c      = '0;

        case (state_q)
            S_IDLE: begin
                start_ready_c = 1'b1;
                if (bus.start_valid) begin
                    mode_d  = bus.mode;
                    round_d = '0;
                    pass_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                load_c  = 1'b1;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                round_en_c   = 1'b1;
                last_round_c = last_w;
                if (last_w) begin
                    round_d = '0;
                    if (pass_q == 2'(PASSES - 1)) begin
                        pass_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        pass_d = pass_q + 2'd1;
                    end
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            S_DONE: begin
                done_valid_c = 1'b1;
                if (bus.done_ready) begin
                    clear_c = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_LOAD || state_q == S_ROUND) begin
            pass_decrypt_c = mode_q ^ pass_q[0];
            key_sel_c      = mode_q ? (2'(PASSES - 1) - pass_q) : pass_q;
        end

        // Abort overrides every other command so load/round_en/clear stay one-hot.
        if (abort_w && state_q != S_IDLE) begin
            load_c       = 1'b0;
            round_en_c   = 1'b0;
            done_valid_c = 1'b0;
            clear_c      = 1'b1;
            round_d      = '0;
            pass_d       = '0;
            state_d      = S_IDLE;
        end
    end

    assign bus.start_ready  = start_ready_c & ~rst;
    assign bus.load         = load_c & ~rst;
    assign bus.clear        = clear_c & ~rst;
    assign bus.round_en     = round_en_c & ~rst;
    assign bus.last_round   = last_round_c & ~rst;
    assign bus.done_valid   = done_valid_c & ~rst;
    assign bus.pass_decrypt = pass_decrypt_c & ~rst;
    assign bus.key_sel      = rst ? '0 : key_sel_c;
    assign bus.round_idx    = rst ? '0 : round_q;
    assign bus.pass_idx     = rst ? '0 : pass_q;
    assign bus.busy         = (state_q != S_IDLE) & ~rst;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Randomized bench for des_round_sequencer with a cycles-since-accept reference model.
// Define SEQ_ABORT_EN to also exercise the abort input.
module tb_des_round_sequencer;
    localparam int ROUNDS  = 16;
    localparam int PASSES  = 3;
    localparam int ROUND_W = 4;
    localparam int TOTAL   = ROUNDS * PASSES;

    logic clk = 1'b0;
    logic rst;
    logic abort = 1'b0;

    des_round_sequencer_if #(.ROUND_W(ROUND_W)) bus ();

    des_round_sequencer #(
        .ROUNDS (ROUNDS),
        .PASSES (PASSES),
        .ROUND_W(ROUND_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef SEQ_ABORT_EN
        .abort(abort),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: idle, or busy with m_t = cycles since the accepting edge (1 = load cycle).
    bit m_busy = 1'b0;
    int m_t    = 0;
    bit m_mode = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (bus.start_valid) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_mode = bus.mode;
            end
        end else if (abort) begin
            m_busy = 1'b0;
        end else if (m_t >= TOTAL + 2) begin
            if (bus.done_ready) m_busy = 1'b0;
        end else begin
            m_t++;
        end
    end

    always @(negedge clk) begin
        bit e_busy, ab, e_load, e_ren, e_dv, e_clr;
        int k, r, p;
        e_busy = !rst && m_busy;
        ab     = e_busy && abort;
        e_load = e_busy && !ab && m_t == 1;
        e_ren  = e_busy && !ab && m_t >= 2 && m_t <= TOTAL + 1;
        e_dv   = e_busy && !ab && m_t >= TOTAL + 2;
        e_clr  = ab || (e_dv && bus.done_ready);
        chk("start_ready", bus.start_ready, int'(!rst && !m_busy));
        chk("busy", bus.busy, int'(e_busy));
        chk("load", bus.load, int'(e_load));
        chk("round_en", bus.round_en, int'(e_ren));
        chk("done_valid", bus.done_valid, int'(e_dv));
        chk("clear", bus.clear, int'(e_clr));
        if (rst) begin
            chk("rst_round_idx", bus.round_idx, 0);
            chk("rst_pass_idx", bus.pass_idx, 0);
            chk("rst_key_sel", bus.key_sel, 0);
            chk("rst_pass_decrypt", bus.pass_decrypt, 0);
            chk("rst_last_round", bus.last_round, 0);
        end else if (!m_busy) begin
            chk("idle_round_idx", bus.round_idx, 0);
            chk("idle_pass_idx", bus.pass_idx, 0);
        end else if (!ab && m_t <= TOTAL + 1) begin
            k = (m_t < 2) ? 0 : m_t - 2;
            r = k % ROUNDS;
            p = k / ROUNDS;
            chk("round_idx", bus.round_idx, r);
            chk("pass_idx", bus.pass_idx, p);
            chk("last_round", bus.last_round, int'(e_ren && r == ROUNDS - 1));
            chk("key_sel", bus.key_sel, m_mode ? (PASSES - 1 - p) : p);
            chk("pass_decrypt", bus.pass_decrypt, int'(m_mode ^ p[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge with the DUT idle; the current cycle is cycle 0.
    task automatic directed(input bit md, input bit toggle);
        bus.mode        = md;
        bus.start_valid = 1'b1;
        bus.done_ready  = 1'b1;
        for (int c = 1; c <= 51; c++) begin
            step();
            if (c == 1) bus.start_valid = 1'b0;
            if (toggle) bus.mode = 1'($urandom);
            @(negedge clk);
            if (c == 1) chk("lit_load@1", bus.load, 1);
            if (c == 2) begin
                chk("lit_key_p0", bus.key_sel, md ? 2 : 0);
                chk("lit_pd_p0", bus.pass_decrypt, int'(md));
            end
            if (c == 18) begin
                chk("lit_key_p1", bus.key_sel, 1);
                chk("lit_pd_p1", bus.pass_decrypt, int'(!md));
            end
            if (c == 34) begin
                chk("lit_key_p2", bus.key_sel, md ? 0 : 2);
                chk("lit_pd_p2", bus.pass_decrypt, int'(md));
            end
            if (c == 16) chk("lit_last@16", bus.last_round, 0);
            if (c == 17 || c == 33 || c == 49) chk("lit_last", bus.last_round, 1);
            if (c == 49) chk("lit_dv@49", bus.done_valid, 0);
            if (c == 50) begin
                chk("lit_dv@50", bus.done_valid, 1);
                chk("lit_clear@50", bus.clear, 1);
            end
            if (c == 51) chk("lit_ready@51", bus.start_ready, 1);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.start_valid = 1'b1;
        bus.mode        = 1'b0;
        bus.done_ready  = 1'b0;

        @(negedge clk);
        chk("lit_rst_ready", bus.start_ready, 0);
        step();
        step();
        step();
        rst             = 1'b0;
        bus.start_valid = 1'b0;
        @(negedge clk);
        chk("lit_post_rst_ready", bus.start_ready, 1);
        chk("lit_post_rst_busy", bus.busy, 0);

        directed(1'b0, 1'b0);
        directed(1'b1, 1'b0);
        directed(1'b1, 1'b1);
        directed(1'b0, 1'b1);

        // Backpressure: result held ten cycles while requests are ignored.
        bus.start_valid = 1'b1;
        bus.mode        = 1'($urandom);
        bus.done_ready  = 1'b0;
        for (int c = 1; c <= 62; c++) begin
            step();
            bus.done_ready = (c >= 60);
            if (c >= 61) bus.start_valid = 1'b0;
            @(negedge clk);
            if (c == 59) chk("lit_bp_dv@59", bus.done_valid, 1);
            if (c == 60) chk("lit_bp_clear@60", bus.clear, 1);
            if (c == 61) chk("lit_bp_ready@61", bus.start_ready, 1);
        end

        // Reset at round 7 of pass 1.
        bus.start_valid = 1'b1;
        bus.done_ready  = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            step();
            if (c == 1) bus.start_valid = 1'b0;
            if (c == 25) rst = 1'b1;
            if (c == 26) rst = 1'b0;
            @(negedge clk);
            if (c == 24) chk("lit_pre_rst_round", bus.round_idx, 6);
            if (c == 26) begin
                chk("lit_rst_mid_busy", bus.busy, 0);
                chk("lit_rst_mid_round", bus.round_idx, 0);
                chk("lit_rst_mid_pass", bus.pass_idx, 0);
                chk("lit_rst_mid_dv", bus.done_valid, 0);
            end
        end

`ifdef SEQ_ABORT_EN
        bus.start_valid = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step();
            bus.start_valid = (c == 21);
            abort           = (c == 20);
            @(negedge clk);
            if (c == 20) begin
                chk("lit_abort_clear", bus.clear, 1);
                chk("lit_abort_ren", bus.round_en, 0);
            end
            if (c == 21) chk("lit_abort_ready", bus.start_ready, 1);
            if (c == 22) chk("lit_abort_reload", bus.load, 1);
        end
`endif

        for (int i = 0; i < 4000; i++) begin
            step();
            rst             = ($urandom_range(0, 299) == 0);
            bus.start_valid = ($urandom_range(0, 3) == 0);
            bus.mode        = 1'($urandom);
            bus.done_ready  = ($urandom_range(0, 2) != 0);
`ifdef SEQ_ABORT_EN
            abort = ($urandom_range(0, 149) == 0);
`endif
        end
        step();
        rst             = 1'b0;
        bus.start_valid = 1'b0;
        abort           = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
